// File: rtl/muldiv_unit_if.sv
// Pipeline-to-multiply/divide-unit bundle: request, operands, HI/LO moves and result status.
// The pipeline (master) drives requests; the unit (slave) returns Busy/Done/Div0 and HI/LO.
interface muldiv_unit_if;
   logic        Start;
   logic [1:0]  Op;
   logic [31:0] Rdata1;
   logic [31:0] Rdata2;
   logic        MtHi;
   logic        MtLo;
   logic        Busy;
   logic        Done;
   logic        Div0;
   logic [31:0] HI;
   logic [31:0] LO;

   // Start is a request, not a valid/ready pair: it is taken on an edge where the
   // unit is IDLE or DONE (Busy low) and ignored otherwise; Done pulses once per result.
   modport master (
      output Start, Op, Rdata1, Rdata2, MtHi, MtLo,
      input  Busy, Done, Div0, HI, LO
   );

   modport slave (
      input  Start, Op, Rdata1, Rdata2, MtHi, MtLo,
      output Busy, Done, Div0, HI, LO
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle on operand magnitudes, sign fix-up at the end.
module muldiv_unit (
   input  logic               CLK,
   input  logic               RST,
   muldiv_unit_if.slave       bus,
   output logic [1:0]         o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CALC  = 2'd1,
      S_FIXUP = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      r_state;
   logic [5:0]  r_cnt;
   logic [63:0] r_p;
   logic [31:0] r_b;
   logic        r_is_div;
   logic        r_sa;
   logic        r_sb;
   logic        r_div0;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        r_busy;
   logic        r_done;
   logic        r_div0_out;

   logic        w_a_neg;
   logic        w_b_neg;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [32:0] w_msum;
   logic [63:0] w_mul_next;
   logic [32:0] w_dshift;
   logic        w_dok;
   logic [31:0] w_drem;
   logic [63:0] w_div_next;
   logic [63:0] w_prod;
   logic [31:0] w_quo;
   logic [31:0] w_rem;

   // Op[0] selects unsigned, Op[1] selects divide.
   assign w_a_neg = ~bus.Op[0] & bus.Rdata1[31];
   assign w_b_neg = ~bus.Op[0] & bus.Rdata2[31];
   assign w_a_mag = w_a_neg ? -bus.Rdata1 : bus.Rdata1;
   assign w_b_mag = w_b_neg ? -bus.Rdata2 : bus.Rdata2;

   assign w_msum     = {1'b0, r_p[63:32]} + (r_p[0] ? {1'b0, r_b} : 33'd0);
   assign w_mul_next = {w_msum, r_p[31:1]};

   // A shifted remainder with bit 32 set always exceeds the divisor; the low 32 bits of the difference are exact.
   assign w_dshift   = {r_p[63:32], r_p[31]};
   assign w_dok      = w_dshift[32] | (w_dshift[31:0] >= r_b);
   assign w_drem     = w_dok ? (w_dshift[31:0] - r_b) : w_dshift[31:0];
   assign w_div_next = {w_drem, r_p[30:0], w_dok};

   assign w_prod = (r_sa ^ r_sb) ? -r_p : r_p;
   assign w_quo  = r_div0 ? 32'hFFFF_FFFF : ((r_sa ^ r_sb) ? -r_p[31:0] : r_p[31:0]);
   assign w_rem  = r_sa ? -r_p[63:32] : r_p[63:32];

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state    <= S_IDLE;
         r_cnt      <= 6'd0;
         r_p        <= 64'd0;
         r_b        <= 32'd0;
         r_is_div   <= 1'b0;
         r_sa       <= 1'b0;
         r_sb       <= 1'b0;
         r_div0     <= 1'b0;
         r_hi       <= 32'd0;
         r_lo       <= 32'd0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_div0_out <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_div0_out <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (bus.Start) begin
                  r_p      <= {32'd0, w_a_mag};
                  r_b      <= w_b_mag;
                  r_is_div <= bus.Op[1];
                  r_sa     <= w_a_neg;
                  r_sb     <= w_b_neg;
                  r_div0   <= bus.Op[1] & (bus.Rdata2 == 32'd0);
                  r_cnt    <= 6'd0;
                  r_busy   <= 1'b1;
                  r_state  <= S_CALC;
               end else begin
                  if (bus.MtHi) r_hi <= bus.Rdata1;
                  if (bus.MtLo) r_lo <= bus.Rdata1;
                  r_state <= S_IDLE;
               end
            end
            S_CALC: begin
               if (r_cnt == 6'd32) begin
                  r_state <= S_FIXUP;
               end else begin
                  r_cnt <= r_cnt + 6'd1;
                  r_p   <= r_is_div ? w_div_next : w_mul_next;
               end
            end
            S_FIXUP: begin
               if (r_is_div) begin
                  r_hi <= w_rem;
                  r_lo <= w_quo;
               end else begin
                  r_hi <= w_prod[63:32];
                  r_lo <= w_prod[31:0];
               end
               r_busy     <= 1'b0;
               r_done     <= 1'b1;
               r_div0_out <= r_div0;
               r_state    <= S_DONE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.Busy    = r_busy;
   assign bus.Done    = r_done;
   assign bus.Div0    = r_div0_out;
   assign bus.HI      = r_hi;
   assign bus.LO      = r_lo;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed results, latency, move/start interplay, reset abort, back-to-back.
module tb_muldiv_unit;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   logic       CLK;
   logic       RST;
   logic [1:0] dbg_state;
   int         n_tests;
   int         n_fail;

   muldiv_unit_if bus_if ();

   muldiv_unit dut (
      .CLK         (CLK),
      .RST         (RST),
      .bus         (bus_if),
      .o_dbg_state (dbg_state)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge CLK);
      bus_if.Start  = 1'b1;
      bus_if.Op     = op;
      bus_if.Rdata1 = a;
      bus_if.Rdata2 = b;
      @(posedge CLK);
      #1;
      bus_if.Start  = 1'b0;
      bus_if.Rdata1 = 32'hDEAD_BEEF;
      bus_if.Rdata2 = 32'h0000_0000;
      check("busy_after_start", {63'd0, bus_if.Busy}, 64'd1);
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (bus_if.Done !== 1'b1 && lat < 60) begin
         @(posedge CLK);
         #1;
         lat++;
      end
   endtask

   task automatic finish_op(input string tag, input int exp_lat, input logic [31:0] exp_hi,
                            input logic [31:0] exp_lo, input logic exp_div0);
      int lat;
      wait_done(lat);
      check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "_hi"}, {32'd0, bus_if.HI}, {32'd0, exp_hi});
      check({tag, "_lo"}, {32'd0, bus_if.LO}, {32'd0, exp_lo});
      check({tag, "_div0"}, {63'd0, bus_if.Div0}, {63'd0, exp_div0});
      check({tag, "_busy_in_done"}, {63'd0, bus_if.Busy}, 64'd0);
      @(posedge CLK);
      #1;
      check({tag, "_done_one_cycle"}, {63'd0, bus_if.Done}, 64'd0);
      check({tag, "_div0_one_cycle"}, {63'd0, bus_if.Div0}, 64'd0);
   endtask

   task automatic op_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo, input logic exp_div0);
      issue(op, a, b);
      finish_op(tag, 34, exp_hi, exp_lo, exp_div0);
   endtask

   initial begin
      int t[3];
      int nd;
      int cyc;
      int seen;
      int lat;
      n_tests = 0;
      n_fail  = 0;
      t       = '{0, 0, 0};
      RST           = 1'b0;
      bus_if.Start  = 1'b0;
      bus_if.Op     = 2'b00;
      bus_if.Rdata1 = 32'd0;
      bus_if.Rdata2 = 32'd0;
      bus_if.MtHi   = 1'b0;
      bus_if.MtLo   = 1'b0;

      #2;
      check("rst_hi", {32'd0, bus_if.HI}, 64'd0);
      check("rst_lo", {32'd0, bus_if.LO}, 64'd0);
      check("rst_busy", {63'd0, bus_if.Busy}, 64'd0);
      check("rst_done", {63'd0, bus_if.Done}, 64'd0);
      check("rst_div0", {63'd0, bus_if.Div0}, 64'd0);
      check("rst_state", {62'd0, dbg_state}, 64'd0);

      // First Start is presented before release and must be taken on the first edge after it.
      @(negedge CLK);
      bus_if.Start  = 1'b1;
      bus_if.Op     = OP_MULT;
      bus_if.Rdata1 = 32'hFFFF_FFFE;
      bus_if.Rdata2 = 32'd3;
      #2 RST = 1'b1;
      @(posedge CLK);
      #1;
      bus_if.Start  = 1'b0;
      bus_if.Rdata1 = 32'h5555_5555;
      bus_if.Rdata2 = 32'h7777_7777;
      check("first_start_busy", {63'd0, bus_if.Busy}, 64'd1);
      finish_op("mult_neg2x3", 34, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);

      op_check("multu_fffffffex3", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0);
      op_check("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      op_check("mult_neg_neg", OP_MULT, 32'hFFFF_FFF9, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0023, 1'b0);
      op_check("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      op_check("divu_7_2", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
      op_check("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
      op_check("div_m9_0", OP_DIV, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1);
      op_check("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
      op_check("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'd16, 32'd15, 32'h0FFF_FFFF, 1'b0);

      // HI/LO moves in IDLE.
      @(negedge CLK);
      bus_if.MtHi = 1'b1;
      bus_if.Rdata1 = 32'h1111_1111;
      @(negedge CLK);
      bus_if.MtHi = 1'b0;
      bus_if.MtLo = 1'b1;
      bus_if.Rdata1 = 32'h2222_2222;
      @(negedge CLK);
      bus_if.MtLo = 1'b0;
      check("mthi", {32'd0, bus_if.HI}, 64'h1111_1111);
      check("mtlo", {32'd0, bus_if.LO}, 64'h2222_2222);
      bus_if.MtHi = 1'b1;
      bus_if.MtLo = 1'b1;
      bus_if.Rdata1 = 32'h3333_3333;
      @(negedge CLK);
      bus_if.MtHi = 1'b0;
      bus_if.MtLo = 1'b0;
      check("mt_both_hi", {32'd0, bus_if.HI}, 64'h3333_3333);
      check("mt_both_lo", {32'd0, bus_if.LO}, 64'h3333_3333);

      // Start and MtHi pulsed mid-operation must both be ignored.
      issue(OP_MULT, 32'd6, 32'd7);
      repeat (9) @(posedge CLK);
      @(negedge CLK);
      bus_if.Start  = 1'b1;
      bus_if.Op     = OP_DIVU;
      bus_if.MtHi   = 1'b1;
      bus_if.Rdata1 = 32'h0000_1234;
      bus_if.Rdata2 = 32'd1;
      @(posedge CLK);
      #1;
      bus_if.Start = 1'b0;
      bus_if.MtHi  = 1'b0;
      check("busy_mid_op", {63'd0, bus_if.Busy}, 64'd1);
      check("hi_stable_calc", {32'd0, bus_if.HI}, 64'h3333_3333);
      check("lo_stable_calc", {32'd0, bus_if.LO}, 64'h3333_3333);
      finish_op("mult_6x7_ignored", 24, 32'd0, 32'd42, 1'b0);
      check("no_queued_start", {63'd0, bus_if.Busy}, 64'd0);

      // Reset mid-divide aborts and clears HI/LO.
      issue(OP_DIVU, 32'd100, 32'd7);
      repeat (20) @(posedge CLK);
      #1 RST = 1'b0;
      #1;
      check("abort_hi", {32'd0, bus_if.HI}, 64'd0);
      check("abort_lo", {32'd0, bus_if.LO}, 64'd0);
      check("abort_busy", {63'd0, bus_if.Busy}, 64'd0);
      check("abort_state", {62'd0, dbg_state}, 64'd0);
      #2 RST = 1'b1;
      @(negedge CLK);
      bus_if.MtLo   = 1'b1;
      bus_if.Rdata1 = 32'h0000_ABCD;
      @(posedge CLK);
      #1;
      bus_if.MtLo = 1'b0;
      check("mtlo_after_reset", {32'd0, bus_if.LO}, 64'h0000_ABCD);
      check("hi_after_reset", {32'd0, bus_if.HI}, 64'd0);
      seen = 0;
      repeat (40) begin
         @(posedge CLK);
         #1;
         if (bus_if.Done === 1'b1) seen++;
      end
      check("no_done_after_abort", 64'(seen), 64'd0);
      check("lo_kept_after_abort", {32'd0, bus_if.LO}, 64'h0000_ABCD);

      // Start held high: operations accepted back-to-back.
      @(negedge CLK);
      bus_if.Start  = 1'b1;
      bus_if.Op     = OP_MULTU;
      bus_if.Rdata1 = 32'd3;
      bus_if.Rdata2 = 32'd5;
      nd  = 0;
      cyc = 0;
      while (nd < 3 && cyc < 200) begin
         @(posedge CLK);
         #1;
         cyc++;
         if (bus_if.Done === 1'b1) begin
            t[nd] = cyc;
            nd++;
         end
      end
      bus_if.Start = 1'b0;
      check("b2b_done_count", 64'(nd), 64'd3);
      check("b2b_first", 64'(t[0]), 64'd35);
      check("b2b_gap1", 64'(t[1] - t[0]), 64'd35);
      check("b2b_gap2", 64'(t[2] - t[1]), 64'd35);
      check("b2b_lo", {32'd0, bus_if.LO}, 64'd15);
      check("b2b_hi", {32'd0, bus_if.HI}, 64'd0);
      @(posedge CLK);
      #1;
      check("b2b_stopped", {63'd0, bus_if.Busy}, 64'd0);
      lat = 0;
      wait_done(lat);
      check("b2b_no_extra_done", 64'(lat), 64'd60);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have no parameters; datapath width fixed at 32 bits.
REQ-002 SHALL have CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have RST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have Start  input  1  request a multiply/divide; sampled only in IDLE.
REQ-005 SHALL have Op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 SHALL have Rdata1  input  32  multiplicand/dividend (rs).
REQ-007 SHALL have Rdata2  input  32  multiplier/divisor (rt).
REQ-008 SHALL have MtHi  input  1  write Rdata1 into HI.
REQ-009 SHALL have MtLo  input  1  write Rdata1 into LO.
REQ-010 SHALL have Busy  output  1  high while an operation is in progress; the pipeline stalls MFHI/MFLO/MTHI/MTLO/mult/div on it.
REQ-011 SHALL have Done  output  1  one-cycle pulse when HI/LO hold a new result.
REQ-012 SHALL have Div0  output  1  high with Done when the completed divide had a zero divisor.
REQ-013 SHALL have HI, LO  output  32 each  architectural HI/LO registers.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIXUP, DONE.
REQ-015 IDLE: Start=1 at an edge SHALL latch operand magnitudes, Op and operand signs, clear the 6-bit iteration counter, and enter CALC.
REQ-016 CALC SHALL perform one iteration per cycle: shift-add for multiply (64-bit product), restoring shift-subtract for divide; exactly 32 cycles, then FIXUP.
REQ-017 Signed ops SHALL operate on absolute values; FIXUP SHALL negate the product if the operand signs differ, negate the quotient if the signs differ, and give the remainder the dividend's sign.
REQ-018 FIXUP SHALL write HI (product[63:32] or remainder) and LO (product[31:0] or quotient) in one edge, then enter DONE.
REQ-019 DONE SHALL assert Done (and Div0 when applicable) for exactly one cycle, then return to IDLE; Busy SHALL be low in DONE.
REQ-020 Latency: Start sampled at edge E0; Busy high from E0 to E34; HI/LO updated at E34; Done high in the cycle after E34; a new Start is accepted at E35.
REQ-021 Busy SHALL be high in CALC and FIXUP only; HI/LO SHALL never change during CALC.
REQ-022 Start asserted outside IDLE SHALL be ignored (no queuing).
REQ-023 MtHi/MtLo SHALL take effect at the next edge only in IDLE or DONE; they are ignored while Busy.
REQ-024 MtHi/MtLo asserted in the same cycle as an accepted Start: Start wins; the move is dropped.
REQ-025 MtHi and MtLo asserted together SHALL write Rdata1 to both HI and LO.
REQ-026 Divide by zero (DIV or DIVU): still SHALL take 32 cycles; LO=32'hFFFFFFFF, HI=Rdata1, Div0=1 with Done.
REQ-027 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0, Div0=0.
REQ-028 Operands SHALL be captured at Start; changes on Rdata1/Rdata2 afterwards SHALL have no effect.

Reset
REQ-029 RST low SHALL immediately force IDLE, HI=0, LO=0, Busy=0, Done=0, Div0=0, and counter=0, regardless of clock.
REQ-030 RST asserted mid-operation SHALL abort it; no partial result SHALL reach HI/LO after release.
REQ-031 The first Start SHALL be accepted on the first rising edge after RST goes high.

Verification
REQ-032 MULT Rdata1=0xFFFFFFFE (-2), Rdata2=3 -> Done after 35 cycles, HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-033 DIV -7 / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU 7 / 2 -> LO=3, HI=1.
REQ-034 DIVU 5 / 0 -> LO=0xFFFFFFFF, HI=5, Div0=1 for one cycle with Done.
REQ-035 Start MULT, then pulse Start and MtHi=1 (Rdata1=0x1234) at cycle 10 -> both ignored; Busy stays high; final HI/LO = the first product.
REQ-036 Start DIVU, drop RST at cycle 20 for 3 ns between edges -> HI=LO=0, Busy=0 immediately, no Done; after release MtLo=0xABCD -> LO=0xABCD next edge.
REQ-037 Back-to-back: Start held high continuously -> a new operation accepted every 35 cycles, Done pulses exactly 35 cycles apart.
